transform_column: RTL and testbench
===================================

Name: transform_column

Overview:
- Single-column AES MixColumns transform (FIPS-197 §5.1.3); multiplies one 4-byte state column by the fixed GF(2^8) circulant matrix [02 03 01 01].
- Used inside the AES round datapath, once per column; four instances, or one time-multiplexed instance, cover a full 128-bit state.
- Registered output stage with a valid strobe; one clock domain.

Parameters:
- None. All widths are fixed by AES (8-bit bytes, 4 bytes per column).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  in0..in3 carry a column to transform this cycle
- in0  input  8  column byte row 0 (a0)
- in1  input  8  column byte row 1 (a1)
- in2  input  8  column byte row 2 (a2)
- in3  input  8  column byte row 3 (a3)
- out_valid  output  1  out0..out3 hold a freshly transformed column
- out0  output  8  result byte row 0 (b0)
- out1  output  8  result byte row 1 (b1)
- out2  output  8  result byte row 2 (b2)
- out3  output  8  result byte row 3 (b3)

Behaviour:
- Arithmetic is in GF(2^8) with modulus x^8+x^4+x^3+x+1 (0x11B). Addition is XOR.
- xtime(a) = {a[6:0],1'b0} XOR (a[7] ? 8'h1B : 8'h00). Multiply by 03 = xtime(a) XOR a.
- Output bytes:
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- Combinational GF math; results are registered on the rising clk edge.
- Latency is exactly 1 cycle: in_valid=1 at edge N gives out_valid=1 and the result after edge N.
- Throughput is one column per cycle. There is no backpressure and no ready signal.
- When in_valid=0 at an edge:
  - out_valid is cleared to 0.
  - out0..out3 hold their previous value and do not update.
- Back-to-back valid inputs produce back-to-back results, each column independent. There is no internal state other than the output registers.
- Reset: when rst_n=0 at a rising edge:
  - out0..out3 are set to 8'h00 and out_valid is set to 0.
  - Reset overrides in_valid in the same cycle.
  - Reset asserted mid-stream drops the in-flight column.
  - The first valid input after rst_n returns high is processed normally.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: MIXCOL_INV_EN.
- Defined:
  - Adds input port inv (1 bit). inv is sampled with in_valid.
  - inv=0 computes forward MixColumns as above.
  - inv=1 computes InvMixColumns with matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E], built from chained xtime.
  - Latency stays 1 cycle.
- Not defined:
  - Port inv is absent.
  - Only forward MixColumns is implemented.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in=db,13,53,45 -> out0..out3=00, out_valid=0 throughout.
- Standard vector: in=db,13,53,45 with in_valid=1 -> one cycle later out=8e,4d,a1,bc, out_valid=1.
- Back-to-back stream: inputs f2,0a,22,5c; d4,d4,d4,d5; 2d,26,31,4c on consecutive cycles -> outputs on consecutive cycles:
  - 9f,dc,58,9d
  - d5,d5,d7,d6
  - 4d,7e,bd,f8
- Fixed points and hold:
  - 01,01,01,01 -> 01,01,01,01.
  - c6,c6,c6,c6 -> c6,c6,c6,c6.
  - Then drop in_valid and change inputs -> out_valid=0, outputs unchanged.
- Mid-stream reset: valid column at edge N, rst_n=0 at edge N+1 -> outputs 00 and out_valid 0 after N+1. The next valid column after reset releases is transformed correctly.
- MIXCOL_INV_EN defined: inv=1, in=8e,4d,a1,bc -> db,13,53,45. inv=1, in=9f,dc,58,9d -> f2,0a,22,5c.

Source files
------------

// File: rtl/transform_column.sv
// Single-column AES MixColumns with a registered output stage and valid strobe.
// Define MIXCOL_INV_EN to add the inv input, which selects InvMixColumns.
module transform_column (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
`ifdef MIXCOL_INV_EN
    input  logic       inv,
`endif
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    output logic       out_valid,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

`ifdef MIXCOL_INV_EN
    // Inverse coefficients are sums of a, 2a, 4a and 8a built from chained xtime.
    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction
`endif

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;

    always_comb begin
        b0 = xtime(in0) ^ mul3(in1) ^ in2 ^ in3;
        b1 = in0 ^ xtime(in1) ^ mul3(in2) ^ in3;
        b2 = in0 ^ in1 ^ xtime(in2) ^ mul3(in3);
        b3 = mul3(in0) ^ in1 ^ in2 ^ xtime(in3);
`ifdef MIXCOL_INV_EN
        if (inv) begin
            b0 = mule(in0) ^ mulb(in1) ^ muld(in2) ^ mul9(in3);
            b1 = mul9(in0) ^ mule(in1) ^ mulb(in2) ^ muld(in3);
            b2 = muld(in0) ^ mul9(in1) ^ mule(in2) ^ mulb(in3);
            b3 = mulb(in0) ^ muld(in1) ^ mul9(in2) ^ mule(in3);
        end
`endif
    end

    // Data registers only load on valid columns so the last result stays visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out0      <= 8'h00;
            out1      <= 8'h00;
            out2      <= 8'h00;
            out3      <= 8'h00;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out0 <= b0;
                out1 <= b1;
                out2 <= b2;
                out3 <= b3;
            end
        end
    end

endmodule

// File: tb/tb_transform_column.sv
// Directed self-checking bench for transform_column using known AES MixColumns vectors.
// Inverse-mode vectors run only when MIXCOL_INV_EN is defined.
module tb_transform_column;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
`ifdef MIXCOL_INV_EN
    logic       inv;
`endif
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic       out_valid;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;

    int checks;
    int errors;

    transform_column dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef MIXCOL_INV_EN
        .inv       (inv),
`endif
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_valid (out_valid),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1 ns later.
    task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] col);
        rst_n    = rst;
        in_valid = v;
        {in0, in1, in2, in3} = col;
        @(posedge clk);
        #1;
    endtask

    task automatic checkColumn(input string tag, input logic v, input logic [31:0] col);
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        checkOutput({tag, ".out"}, {out0, out1, out2, out3}, col);
    endtask

    logic [31:0] streamIn  [3];
    logic [31:0] streamOut [3];

    initial begin
        checks = 0;
        errors = 0;
        streamIn[0] = 32'hf20a225c; streamOut[0] = 32'h9fdc589d;
        streamIn[1] = 32'hd4d4d4d5; streamOut[1] = 32'hd5d5d7d6;
        streamIn[2] = 32'h2d26314c; streamOut[2] = 32'h4d7ebdf8;
`ifdef MIXCOL_INV_EN
        inv = 1'b0;
`endif
        rst_n = 1'b0;
        in_valid = 1'b0;
        {in0, in1, in2, in3} = 32'h0;
        #2;

        // Reset wins over in_valid
        applyStimulus(1'b0, 1'b1, 32'hdb135345);
        checkColumn("reset1", 1'b0, 32'h00000000);
        applyStimulus(1'b0, 1'b1, 32'hdb135345);
        checkColumn("reset2", 1'b0, 32'h00000000);

        applyStimulus(1'b1, 1'b1, 32'hdb135345);
        checkColumn("std", 1'b1, 32'h8e4da1bc);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, streamIn[i]);
            checkColumn($sformatf("stream%0d", i), 1'b1, streamOut[i]);
        end

        applyStimulus(1'b1, 1'b1, 32'h01010101);
        checkColumn("fix01", 1'b1, 32'h01010101);
        applyStimulus(1'b1, 1'b1, 32'hc6c6c6c6);
        checkColumn("fixc6", 1'b1, 32'hc6c6c6c6);

        applyStimulus(1'b1, 1'b0, 32'h00112233);
        checkColumn("hold1", 1'b0, 32'hc6c6c6c6);
        applyStimulus(1'b1, 1'b0, 32'hdb135345);
        checkColumn("hold2", 1'b0, 32'hc6c6c6c6);

        applyStimulus(1'b1, 1'b1, 32'hdb135345);
        checkColumn("midN", 1'b1, 32'h8e4da1bc);
        applyStimulus(1'b0, 1'b1, 32'hf20a225c);
        checkColumn("midRst", 1'b0, 32'h00000000);
        applyStimulus(1'b1, 1'b1, 32'hd4d4d4d5);
        checkColumn("postRst", 1'b1, 32'hd5d5d7d6);

`ifdef MIXCOL_INV_EN
        inv = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h8e4da1bc);
        checkColumn("inv0", 1'b1, 32'hdb135345);
        applyStimulus(1'b1, 1'b1, 32'h9fdc589d);
        checkColumn("inv1", 1'b1, 32'hf20a225c);
        inv = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'hdb135345);
        checkColumn("fwdAgain", 1'b1, 32'h8e4da1bc);
`endif

        applyStimulus(1'b1, 1'b0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
